// File: rtl/unit_dispatcher_if.sv
// unit_dispatcher_if: host command handshake and processing-unit control bundle.
// The host/unit side uses the master modport; the dispatcher uses the slave modport.
interface unit_dispatcher_if #(
    parameter int unsigned UNIT_COUNT = 4
);
    localparam int unsigned UW = (UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [UW-1:0]         cmd_dst;
    logic [UW-1:0]         cmd_src;
    logic [UNIT_COUNT-1:0] unit_ready;
    logic [UNIT_COUNT-1:0] unit_done;
    logic [UNIT_COUNT-1:0] unit_start;
    logic [2:0]            unit_op;
    logic [UW-1:0]         unit_src;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, unit_ready, unit_done,
        input  cmd_ready, unit_start, unit_op, unit_src
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, unit_ready, unit_done,
        output cmd_ready, unit_start, unit_op, unit_src
    );
endinterface

// File: rtl/unit_dispatcher.sv
// unit_dispatcher: in-order command scheduler feeding the processing_unit array.
// Commands are buffered in a FIFO and issued to their destination unit once the
// destination (and, for COPY/ADD_VEC, the source) unit is idle.
// Optional macro UNIT_DISPATCHER_PERF_EN adds the stall_cycles counter output.
module unit_dispatcher #(
    parameter int unsigned UNIT_COUNT = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    unit_dispatcher_if.slave      bus,
    input  logic                  flush,
    output logic [UNIT_COUNT-1:0] busy,
    output logic                  idle,
    output logic                  spurious_done
`ifdef UNIT_DISPATCHER_PERF_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    localparam int unsigned OP_W = 3;
    localparam int unsigned UW   = (UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned EW   = OP_W + 2 * UW;

    localparam logic [OP_W-1:0] OP_COPY    = 3'd3;
    localparam logic [OP_W-1:0] OP_ADD_VEC = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic [UNIT_COUNT-1:0] busy_q;
    logic                  push;
    logic                  pop;
    logic                  issue_go;
    logic                  fifo_empty;
    logic                  ready_nxt;
    logic [EW-1:0]         head;
    logic [OP_W-1:0]       head_op;
    logic [UW-1:0]         head_src;
    logic [UW-1:0]         head_dst;
    logic                  inter_op;
    logic                  hazard_ok;
    logic [UNIT_COUNT-1:0] dst_onehot;

    // Head decode and hazard test
    assign push       = bus.cmd_valid && bus.cmd_ready;
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign head_op    = head[EW-1 -: OP_W];
    assign head_src   = head[2*UW-1 -: UW];
    assign head_dst   = head[UW-1:0];
    assign inter_op   = (head_op == OP_COPY) || (head_op == OP_ADD_VEC);
    assign dst_onehot = UNIT_COUNT'(1) << head_dst;
    assign hazard_ok  = !busy_q[head_dst] && bus.unit_ready[head_dst]
                        && (!inter_op || !busy_q[head_src]);

    assign busy = busy_q;
    assign idle = fifo_empty && (busy_q == '0) && (state == ST_IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state, issue and pop decisions; flush overrides everything
    always_comb begin
        state_nxt = state;
        issue_go  = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty || push) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (hazard_ok) begin
                    state_nxt = ST_ISSUE;
                    issue_go  = 1'b1;
                end
            end
            ST_ISSUE: begin
                pop       = 1'b1;
                state_nxt = ((count > CW'(1)) || push) ? ST_CHECK : ST_IDLE;
            end
            ST_DRAIN: begin
                if (busy_q == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_DRAIN;
            issue_go  = 1'b0;
            pop       = 1'b0;
        end
    end

    assign count_nxt = flush ? '0 : (count + CW'(push) - CW'(pop));
    assign ready_nxt = (state_nxt != ST_DRAIN) && (count_nxt < CW'(FIFO_DEPTH));

    // FIFO storage; a write coincident with flush is dropped
    always_ff @(posedge clk) begin
        if (!rst && push && !flush) begin
            fifo_mem[wr_ptr] <= {bus.cmd_op, bus.cmd_src, bus.cmd_dst};
        end
    end

    // FIFO pointers, occupancy and registered cmd_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.cmd_ready <= 1'b1;
        end else begin
            bus.cmd_ready <= ready_nxt;
            count         <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // Busy tracking, spurious-done detection and registered issue outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            spurious_done  <= 1'b0;
            bus.unit_start <= '0;
            bus.unit_op    <= '0;
            bus.unit_src   <= '0;
        end else begin
            busy_q         <= (busy_q & ~bus.unit_done) | (issue_go ? dst_onehot : '0);
            bus.unit_start <= issue_go ? dst_onehot : '0;
            if (|(bus.unit_done & ~busy_q)) begin
                spurious_done <= 1'b1;
            end
            if (issue_go) begin
                bus.unit_op  <= head_op;
                bus.unit_src <= head_src;
            end
        end
    end

`ifdef UNIT_DISPATCHER_PERF_EN
    // Saturating count of cycles the head sat in CHECK without issuing
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((state == ST_CHECK) && (state_nxt != ST_ISSUE) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unit_dispatcher.sv
// tb_unit_dispatcher: directed scenarios plus a randomized run checked against a
// transaction-level model (expected issue queue and per-unit busy set).
module tb_unit_dispatcher;
    localparam int unsigned UC = 4;
    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_STORE   = 3'd1;
    localparam logic [2:0] OP_COMPUTE = 3'd2;
    localparam logic [2:0] OP_COPY    = 3'd3;
    localparam logic [2:0] OP_ADD_VEC = 3'd4;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] dst;
        logic [1:0] src;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [UC-1:0] busy;
    logic          idle;
    logic          spurious_done;
`ifdef UNIT_DISPATCHER_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    cmd_t exp_q[$];

    unit_dispatcher_if #(.UNIT_COUNT(UC)) bus ();

    unit_dispatcher #(.UNIT_COUNT(UC), .FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .flush        (flush),
        .busy         (busy),
        .idle         (idle),
        .spurious_done(spurious_done)
`ifdef UNIT_DISPATCHER_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_dst   = '0;
        bus.cmd_src   = '0;
        bus.unit_done = '0;
        flush         = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_dst   = dst;
        bus.cmd_src   = src;
    endtask

    task automatic test_reset();
        bus.unit_ready = '1;
        quiet_inputs();
        rst = 1'b1;
        send(OP_LOAD, 2'd0, 2'd0);
        repeat (2) tick();
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got=%b exp=1", idle); end
        n_vec++; if (bus.unit_start !== 4'b0000) begin n_err++; $display("FAIL rst_unit_start got=%b exp=0000", bus.unit_start); end
        n_vec++; if (busy !== 4'b0000) begin n_err++; $display("FAIL rst_busy got=%b exp=0000", busy); end
        n_vec++; if (spurious_done !== 1'b0) begin n_err++; $display("FAIL rst_spurious got=%b exp=0", spurious_done); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (bus.unit_start !== 4'b0000 || idle !== 1'b1) begin
                n_err++; $display("FAIL rst_no_accept start=%b idle=%b exp start=0000 idle=1", bus.unit_start, idle);
            end
        end
    endtask

    task automatic test_single_load();
        do_reset();
        bus.unit_ready = '1;
        send(OP_LOAD, 2'd2, 2'd0);
        tick();
        bus.cmd_valid = 1'b0;
        n_vec++; if (bus.unit_start !== 4'b0000) begin n_err++; $display("FAIL load_early_start got=%b exp=0000", bus.unit_start); end
        tick();
        n_vec++; if (bus.unit_start !== 4'b0100) begin n_err++; $display("FAIL load_start got=%b exp=0100", bus.unit_start); end
        n_vec++; if (bus.unit_op !== OP_LOAD) begin n_err++; $display("FAIL load_op got=%0d exp=%0d", bus.unit_op, OP_LOAD); end
        n_vec++; if (busy !== 4'b0100) begin n_err++; $display("FAIL load_busy got=%b exp=0100", busy); end
        tick();
        n_vec++; if (bus.unit_start !== 4'b0000) begin n_err++; $display("FAIL load_pulse_width got=%b exp=0000", bus.unit_start); end
        repeat (4) tick();
        n_vec++; if (idle !== 1'b0 || busy !== 4'b0100) begin n_err++; $display("FAIL load_busy_hold idle=%b busy=%b exp idle=0 busy=0100", idle, busy); end
        bus.unit_done = 4'b0100;
        tick();
        bus.unit_done = '0;
        n_vec++; if (busy !== 4'b0000) begin n_err++; $display("FAIL load_done_busy got=%b exp=0000", busy); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL load_done_idle got=%b exp=1", idle); end
    endtask

    task automatic test_source_hazard();
        do_reset();
        bus.unit_ready = '1;
        send(OP_COMPUTE, 2'd1, 2'd0);
        tick();
        send(OP_COPY, 2'd0, 2'd1);
        tick();
        bus.cmd_valid = 1'b0;
        n_vec++; if (bus.unit_start !== 4'b0010) begin n_err++; $display("FAIL haz_first_start got=%b exp=0010", bus.unit_start); end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++; if (bus.unit_start !== 4'b0000) begin n_err++; $display("FAIL haz_stall_start got=%b exp=0000", bus.unit_start); end
        end
        bus.unit_done = 4'b0010;
        tick();
        bus.unit_done = '0;
        n_vec++; if (bus.unit_start !== 4'b0000) begin n_err++; $display("FAIL haz_d1_start got=%b exp=0000", bus.unit_start); end
        tick();
        n_vec++; if (bus.unit_start !== 4'b0001) begin n_err++; $display("FAIL haz_copy_start got=%b exp=0001", bus.unit_start); end
        n_vec++; if (bus.unit_src !== 2'd1 || bus.unit_op !== OP_COPY) begin
            n_err++; $display("FAIL haz_copy_fields src=%0d op=%0d exp src=1 op=%0d", bus.unit_src, bus.unit_op, OP_COPY);
        end
        n_vec++; if (busy !== 4'b0001) begin n_err++; $display("FAIL haz_busy got=%b exp=0001", busy); end
`ifdef UNIT_DISPATCHER_PERF_EN
        n_vec++; if (stall_cycles !== 32'd5) begin n_err++; $display("FAIL haz_stall_cycles got=%0d exp=5", stall_cycles); end
`endif
        bus.unit_done = 4'b0001;
        tick();
        bus.unit_done = '0;
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL haz_final_idle got=%b exp=1", idle); end
    endtask

    task automatic test_full_fifo();
        int   accepted;
        int   issued;
        cmd_t c;
        do_reset();
        exp_q.delete();
        bus.unit_ready = '0;
        accepted = 0;
        for (int i = 0; i < 9; i++) begin
            c.op  = 3'(i % 5);
            c.dst = 2'(i % 4);
            c.src = 2'((i + 1) % 4);
            send(c.op, c.dst, c.src);
            if (bus.cmd_ready) begin
                exp_q.push_back(c);
                accepted++;
            end
            tick();
            n_vec++; if (bus.unit_start !== 4'b0000) begin n_err++; $display("FAIL full_no_start got=%b exp=0000", bus.unit_start); end
        end
        bus.cmd_valid = 1'b0;
        n_vec++; if (accepted != 8) begin n_err++; $display("FAIL full_accepted got=%0d exp=8", accepted); end
        n_vec++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_cmd_ready got=%b exp=0", bus.cmd_ready); end
        bus.unit_ready = '1;
        issued = 0;
        for (int cyc = 0; cyc < 200 && issued < 8; cyc++) begin
            tick();
            bus.unit_done = '0;
            if (bus.unit_start != '0) begin
                c = exp_q.pop_front();
                n_vec++; if (bus.unit_start !== (UC'(1) << c.dst) || bus.unit_op !== c.op) begin
                    n_err++; $display("FAIL full_order start=%b op=%0d exp start=%b op=%0d", bus.unit_start, bus.unit_op, UC'(1) << c.dst, c.op);
                end
                issued++;
                bus.unit_done = bus.unit_start;
            end
        end
        n_vec++; if (issued != 8) begin n_err++; $display("FAIL full_issued got=%0d exp=8", issued); end
        tick();
        bus.unit_done = '0;
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL full_final_idle got=%b exp=1", idle); end
        exp_q.delete();
    endtask

    task automatic test_flush();
        do_reset();
        bus.unit_ready = '1;
        send(OP_LOAD, 2'd3, 2'd0);
        tick();
        send(OP_STORE, 2'd3, 2'd0);
        tick();
        n_vec++; if (bus.unit_start !== 4'b1000) begin n_err++; $display("FAIL flush_first_start got=%b exp=1000", bus.unit_start); end
        send(OP_COMPUTE, 2'd3, 2'd0);
        tick();
        send(OP_ADD_VEC, 2'd3, 2'd1);
        tick();
        bus.cmd_valid = 1'b0;
        n_vec++; if (busy !== 4'b1000) begin n_err++; $display("FAIL flush_pre_busy got=%b exp=1000", busy); end
        tick();
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL flush_pre_ready got=%b exp=1", bus.cmd_ready); end
        flush = 1'b1;
        send(OP_LOAD, 2'd0, 2'd0);
        tick();
        flush = 1'b0;
        n_vec++; if (bus.cmd_ready !== 1'b0 || idle !== 1'b0) begin
            n_err++; $display("FAIL flush_drain ready=%b idle=%b exp ready=0 idle=0", bus.cmd_ready, idle);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++; if (bus.cmd_ready !== 1'b0 || bus.unit_start !== 4'b0000) begin
                n_err++; $display("FAIL flush_hold ready=%b start=%b exp ready=0 start=0000", bus.cmd_ready, bus.unit_start);
            end
        end
        bus.cmd_valid = 1'b0;
        bus.unit_done = 4'b1000;
        tick();
        bus.unit_done = '0;
        n_vec++; if (busy !== 4'b0000) begin n_err++; $display("FAIL flush_busy_clear got=%b exp=0000", busy); end
        tick();
        n_vec++; if (bus.cmd_ready !== 1'b1 || idle !== 1'b1) begin
            n_err++; $display("FAIL flush_exit ready=%b idle=%b exp ready=1 idle=1", bus.cmd_ready, idle);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++; if (bus.unit_start !== 4'b0000) begin n_err++; $display("FAIL flush_dropped_issued got=%b exp=0000", bus.unit_start); end
        end
    endtask

    task automatic test_spurious();
        do_reset();
        bus.unit_ready = '1;
        bus.unit_done = 4'b0001;
        tick();
        bus.unit_done = '0;
        n_vec++; if (spurious_done !== 1'b1 || busy !== 4'b0000) begin
            n_err++; $display("FAIL spur_set spurious=%b busy=%b exp spurious=1 busy=0000", spurious_done, busy);
        end
        repeat (3) tick();
        n_vec++; if (spurious_done !== 1'b1) begin n_err++; $display("FAIL spur_sticky got=%b exp=1", spurious_done); end
        do_reset();
        n_vec++; if (spurious_done !== 1'b0) begin n_err++; $display("FAIL spur_rst_clear got=%b exp=0", spurious_done); end
        send(OP_LOAD, 2'd1, 2'd0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        n_vec++; if (busy !== 4'b0010) begin n_err++; $display("FAIL spur_pre_busy got=%b exp=0010", busy); end
        do_reset();
        n_vec++; if (busy !== 4'b0000) begin n_err++; $display("FAIL spur_rst_busy got=%b exp=0000", busy); end
        bus.unit_done = 4'b0010;
        tick();
        bus.unit_done = '0;
        n_vec++; if (spurious_done !== 1'b1) begin n_err++; $display("FAIL spur_abandoned got=%b exp=1", spurious_done); end
    endtask

    task automatic test_random();
        logic [UC-1:0] busy_m;
        logic [UC-1:0] rdy_prev;
        logic [UC-1:0] done_prev;
        logic [UC-1:0] start_exp;
        logic [UC-1:0] v;
        logic          draining;
        logic          inter;
        int            last_start;
        cmd_t          c;
        do_reset();
        exp_q.delete();
        busy_m         = '0;
        last_start     = -10;
        bus.unit_ready = '1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rdy_prev  = bus.unit_ready;
            done_prev = bus.unit_done;
            tick();
            start_exp = '0;
            if (bus.unit_start != '0) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rnd_unexpected_start got=%b exp=0000", bus.unit_start);
                end else begin
                    c         = exp_q.pop_front();
                    start_exp = UC'(1) << c.dst;
                    inter     = (c.op == OP_COPY) || (c.op == OP_ADD_VEC);
                    if (bus.unit_start !== start_exp) begin
                        n_err++; $display("FAIL rnd_start cyc=%0d got=%b exp=%b", cyc, bus.unit_start, start_exp);
                    end
                    n_vec++; if (bus.unit_op !== c.op) begin n_err++; $display("FAIL rnd_op cyc=%0d got=%0d exp=%0d", cyc, bus.unit_op, c.op); end
                    if (inter) begin
                        n_vec++; if (bus.unit_src !== c.src) begin n_err++; $display("FAIL rnd_src cyc=%0d got=%0d exp=%0d", cyc, bus.unit_src, c.src); end
                    end
                    n_vec++; if (busy_m[c.dst] || !rdy_prev[c.dst] || (inter && busy_m[c.src])) begin
                        n_err++; $display("FAIL rnd_hazard cyc=%0d busy=%b ready=%b dst=%0d src=%0d exp hazard-free issue", cyc, busy_m, rdy_prev, c.dst, c.src);
                    end
                    n_vec++; if (cyc - last_start < 2) begin
                        n_err++; $display("FAIL rnd_spacing cyc=%0d gap=%0d exp>=2", cyc, cyc - last_start);
                    end
                end
                last_start = cyc;
            end
            busy_m = (busy_m & ~done_prev) | start_exp;
            n_vec++; if (busy !== busy_m) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, busy_m); end
            n_vec++; if (spurious_done !== 1'b0) begin n_err++; $display("FAIL rnd_spurious cyc=%0d got=%b exp=0", cyc, spurious_done); end
            bus.unit_done = '0;
            bus.cmd_valid = 1'b0;
            draining = (cyc >= 3000);
            if (draining && exp_q.size() == 0 && busy_m == '0) break;
            for (int i = 0; i < UC; i++) begin
                v[i] = busy_m[i] && ($urandom_range(3) == 0);
            end
            bus.unit_done = v;
            for (int i = 0; i < UC; i++) begin
                v[i] = draining || ($urandom_range(3) != 0);
            end
            bus.unit_ready = v;
            if (!draining && $urandom_range(1) == 1) begin
                c.op  = 3'($urandom_range(4));
                c.dst = 2'($urandom_range(3));
                c.src = 2'($urandom_range(3));
                send(c.op, c.dst, c.src);
                if (bus.cmd_ready) begin
                    exp_q.push_back(c);
                end
            end
        end
        n_vec++; if (exp_q.size() != 0 || busy_m != '0) begin
            n_err++; $display("FAIL rnd_drain_timeout pending=%0d busy=%b exp pending=0 busy=0000", exp_q.size(), busy_m);
        end
        tick();
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL rnd_final_idle got=%b exp=1", idle); end
    endtask

    initial begin
        quiet_inputs();
        bus.unit_ready = '1;
        test_reset();
        test_single_load();
        test_source_hazard();
        test_full_fifo();
        test_flush();
        test_spurious();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
